id_ex_latch: RTL and testbench
==============================

ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 SHALL have ports: CLK  in  1  pipeline clock, rising-edge; nRST  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: ihit  in  1  fetch done, stage may advance; mem_busy  in  1  data access pending downstream, freeze; flush  in  1  branch/jump resolved taken, kill ID content.
REQ-003 SHALL have ports: nPC_next, rdat1_next, rdat2_next, imm_next, lui_next  in  32 each  decode payload.
REQ-004 SHALL have ports: regDst_next, rs_next, rt_next  in  5 each; shamt_next  in  5; ALUOp_next  in  4; regSel_next, PCSrc_next, ALUSrc_next  in  2 each; dREN_next, dWEN_next, regWr_next, halt_next  in  1 each.
REQ-005 SHALL have one registered output per REQ-003/004 input, suffix _ex in place of _next, same width.
REQ-006 SHALL have ports: stall_id  out  1  hold PC and IF/ID latch this cycle; bubble_cnt  out  32  bubbles inserted.

Function
REQ-007 SHALL compute en = ihit & ~mem_busy; outputs change only on rising CLK with en=1 (or on reset).
REQ-008 SHALL detect load-use: lu = dREN_ex & regWr_ex & (regDst_ex != 0) & (regDst_ex == rs_next | regDst_ex == rt_next).
REQ-009 SHALL drive stall_id = lu & ~flush, combinational, independent of en.
REQ-010 SHALL on en, priority flush > lu > load: flush or lu loads a bubble; otherwise all _ex <= _next.
REQ-011 SHALL define a bubble as: dREN, dWEN, regWr, halt = 0; PCSrc, ALUSrc, regSel = 0; ALUOp = 0; all 32-bit fields, register indices, shamt = 0.
REQ-012 SHALL hold every _ex output unchanged when en=0, including when flush or lu asserted that cycle.
REQ-013 SHALL deassert lu on the cycle after a bubble is loaded, since dREN_ex=0; stall therefore lasts exactly one advancing cycle.
REQ-014 SHALL treat regDst_ex = 0 as no hazard (writes to $zero ignored).
REQ-015 SHALL latch halt_next like any control bit; a flushed or bubbled halt is discarded.
REQ-016 SHALL have load latency of one advancing edge: _next value at edge N appears on _ex after edge N.

Reset
REQ-017 SHALL on nRST=0, asynchronously and immediately, set every _ex output to the bubble value of REQ-011 and bubble_cnt to 0.
REQ-018 SHALL resume normal operation on the first rising CLK after nRST deasserts; reset mid-stall clears stall source (dREN_ex=0).

Configuration
REQ-019 SHALL compile a bubble counter only when macro IDEX_PERF_CNT_EN is defined.
REQ-020 SHALL with IDEX_PERF_CNT_EN increment bubble_cnt by 1 on each en edge that loads a bubble (flush or lu), saturating at 32'hFFFFFFFF.
REQ-021 SHALL without IDEX_PERF_CNT_EN drive bubble_cnt constant 0 and contain no counter flops.

Verification
REQ-022 SHALL cover pass-through: ihit=1, mem_busy=0, rdat1_next=32'hDEADBEEF, regWr_next=1 -> rdat1_ex=32'hDEADBEEF, regWr_ex=1 after one edge.
REQ-023 SHALL cover load-use: ex holds lw with regDst_ex=8, decode rs_next=8, ihit=1 -> stall_id=1 same cycle, next edge all controls 0, stall_id=0 following cycle, bubble_cnt=1 (macro on).
REQ-024 SHALL cover freeze: mem_busy=1 with changing _next and flush=1 for 3 cycles -> all _ex unchanged, bubble_cnt unchanged.
REQ-025 SHALL cover flush priority: flush=1 and lu=1 with ihit=1 -> stall_id=0, bubble loaded, halt_ex=0 even if halt_next=1.
REQ-026 SHALL cover async reset: nRST pulled low mid-cycle with regWr_ex=1 -> regWr_ex=0 and bubble_cnt=0 before next CLK edge; regDst_ex=0 with rs_next=0 gives stall_id=0.
REQ-027 SHALL cover saturation with IDEX_PERF_CNT_EN: counter forced near 32'hFFFFFFFE, two bubbles -> bubble_cnt=32'hFFFFFFFF, stays there; without macro bubble_cnt=0 throughout.

Source files
------------

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Optional bubble counter is built when IDEX_PERF_CNT_EN is defined.
module id_ex_latch (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        mem_busy,
  input  logic        flush,
  input  logic [31:0] nPC_next,
  input  logic [31:0] rdat1_next,
  input  logic [31:0] rdat2_next,
  input  logic [31:0] imm_next,
  input  logic [31:0] lui_next,
  input  logic [4:0]  regDst_next,
  input  logic [4:0]  rs_next,
  input  logic [4:0]  rt_next,
  input  logic [4:0]  shamt_next,
  input  logic [3:0]  ALUOp_next,
  input  logic [1:0]  regSel_next,
  input  logic [1:0]  PCSrc_next,
  input  logic [1:0]  ALUSrc_next,
  input  logic        dREN_next,
  input  logic        dWEN_next,
  input  logic        regWr_next,
  input  logic        halt_next,
  output logic [31:0] nPC_ex,
  output logic [31:0] rdat1_ex,
  output logic [31:0] rdat2_ex,
  output logic [31:0] imm_ex,
  output logic [31:0] lui_ex,
  output logic [4:0]  regDst_ex,
  output logic [4:0]  rs_ex,
  output logic [4:0]  rt_ex,
  output logic [4:0]  shamt_ex,
  output logic [3:0]  ALUOp_ex,
  output logic [1:0]  regSel_ex,
  output logic [1:0]  PCSrc_ex,
  output logic [1:0]  ALUSrc_ex,
  output logic        dREN_ex,
  output logic        dWEN_ex,
  output logic        regWr_ex,
  output logic        halt_ex,
  output logic        stall_id,
  output logic [31:0] bubble_cnt
);

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [31:0] lui;
    logic [4:0]  reg_dst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic [1:0]  reg_sel;
    logic [1:0]  pc_src;
    logic [1:0]  alu_src;
    logic        dren;
    logic        dwen;
    logic        reg_wr;
    logic        halt;
  } id_ex_t;

  id_ex_t nxt;
  id_ex_t cur;
  id_ex_t dat;
  logic   en;
  logic   lu;
  logic   bub;

  assign nxt = '{
    npc:     nPC_next,
    rdat1:   rdat1_next,
    rdat2:   rdat2_next,
    imm:     imm_next,
    lui:     lui_next,
    reg_dst: regDst_next,
    rs:      rs_next,
    rt:      rt_next,
    shamt:   shamt_next,
    alu_op:  ALUOp_next,
    reg_sel: regSel_next,
    pc_src:  PCSrc_next,
    alu_src: ALUSrc_next,
    dren:    dREN_next,
    dwen:    dWEN_next,
    reg_wr:  regWr_next,
    halt:    halt_next
  };

  // Advance, hazard detect and bubble select; all-zero is the bubble.
  always_comb begin
    en  = ihit & ~mem_busy;
    lu  = cur.dren & cur.reg_wr
        & (cur.reg_dst != 5'd0)
        & ((cur.reg_dst == rs_next)
        | (cur.reg_dst == rt_next));
    bub = flush | lu;
    dat = nxt;
    if (bub)
      dat = '0;
    stall_id = lu & ~flush;
  end

  // Stage register: cleared to a bubble on reset, held while frozen.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cur <= '0;
    else if (en)
      cur <= dat;
  end

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] cnt_q;

  // Count bubbles on advancing edges, saturating at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt_q <= '0;
    else if (en && bub && (cnt_q != 32'hFFFF_FFFF))
      cnt_q <= cnt_q + 32'd1;
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = 32'd0;
`endif

  assign nPC_ex    = cur.npc;
  assign rdat1_ex  = cur.rdat1;
  assign rdat2_ex  = cur.rdat2;
  assign imm_ex    = cur.imm;
  assign lui_ex    = cur.lui;
  assign regDst_ex = cur.reg_dst;
  assign rs_ex     = cur.rs;
  assign rt_ex     = cur.rt;
  assign shamt_ex  = cur.shamt;
  assign ALUOp_ex  = cur.alu_op;
  assign regSel_ex = cur.reg_sel;
  assign PCSrc_ex  = cur.pc_src;
  assign ALUSrc_ex = cur.alu_src;
  assign dREN_ex   = cur.dren;
  assign dWEN_ex   = cur.dwen;
  assign regWr_ex  = cur.reg_wr;
  assign halt_ex   = cur.halt;

endmodule

// File: tb/tb_id_ex_latch.sv
// Bench for id_ex_latch: scoreboard of expected ex bundles and counts.
// Counter expectations follow IDEX_PERF_CNT_EN when it is defined.
module tb_id_ex_latch;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [31:0] lui;
    logic [4:0]  reg_dst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic [1:0]  reg_sel;
    logic [1:0]  pc_src;
    logic [1:0]  alu_src;
    logic        dren;
    logic        dwen;
    logic        reg_wr;
    logic        halt;
  } ex_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit = 1'b0;
  logic mem_busy = 1'b0;
  logic flush = 1'b0;
  ex_t  nx = '0;
  ex_t  got;
  logic stall_id;
  logic [31:0] bubble_cnt;

  ex_t         m = '0;
  logic [31:0] mcnt = '0;
  ex_t         q[$];
  logic [31:0] cq[$];
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  id_ex_latch dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit),
    .mem_busy(mem_busy), .flush(flush),
    .nPC_next(nx.npc), .rdat1_next(nx.rdat1),
    .rdat2_next(nx.rdat2), .imm_next(nx.imm),
    .lui_next(nx.lui), .regDst_next(nx.reg_dst),
    .rs_next(nx.rs), .rt_next(nx.rt),
    .shamt_next(nx.shamt), .ALUOp_next(nx.alu_op),
    .regSel_next(nx.reg_sel), .PCSrc_next(nx.pc_src),
    .ALUSrc_next(nx.alu_src), .dREN_next(nx.dren),
    .dWEN_next(nx.dwen), .regWr_next(nx.reg_wr),
    .halt_next(nx.halt),
    .nPC_ex(got.npc), .rdat1_ex(got.rdat1),
    .rdat2_ex(got.rdat2), .imm_ex(got.imm),
    .lui_ex(got.lui), .regDst_ex(got.reg_dst),
    .rs_ex(got.rs), .rt_ex(got.rt),
    .shamt_ex(got.shamt), .ALUOp_ex(got.alu_op),
    .regSel_ex(got.reg_sel), .PCSrc_ex(got.pc_src),
    .ALUSrc_ex(got.alu_src), .dREN_ex(got.dren),
    .dWEN_ex(got.dwen), .regWr_ex(got.reg_wr),
    .halt_ex(got.halt),
    .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  function automatic logic model_lu();
    return m.dren & m.reg_wr & (m.reg_dst != 5'd0)
         & ((m.reg_dst == nx.rs) | (m.reg_dst == nx.rt));
  endfunction

  function automatic ex_t rand_nx();
    ex_t r;
    r.npc     = $urandom;
    r.rdat1   = $urandom;
    r.rdat2   = $urandom;
    r.imm     = $urandom;
    r.lui     = $urandom;
    r.reg_dst = 5'($urandom_range(0, 3));
    r.rs      = 5'($urandom_range(0, 3));
    r.rt      = 5'($urandom_range(0, 3));
    r.shamt   = 5'($urandom);
    r.alu_op  = 4'($urandom);
    r.reg_sel = 2'($urandom);
    r.pc_src  = 2'($urandom);
    r.alu_src = 2'($urandom);
    r.dren    = 1'($urandom);
    r.dwen    = 1'($urandom);
    r.reg_wr  = 1'($urandom);
    r.halt    = 1'($urandom);
    return r;
  endfunction

  task automatic push_exp();
    ex_t e;
    logic en;
    logic bub;
    en  = ihit & ~mem_busy;
    bub = flush | model_lu();
    e   = m;
    if (en)
      e = bub ? ex_t'('0) : nx;
`ifdef IDEX_PERF_CNT_EN
    if (en && bub && mcnt != 32'hFFFF_FFFF)
      mcnt = mcnt + 32'd1;
`endif
    m = e;
    q.push_back(e);
    cq.push_back(mcnt);
  endtask

  task automatic advance(output ex_t e, output logic [31:0] c);
    @(posedge CLK);
    #1;
    e = '0;
    c = '0;
    if (q.size() == 0 || cq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty got=%0d want=1", q.size());
    end else begin
      e = q.pop_front();
      c = cq.pop_front();
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    m    = '0;
    mcnt = '0;
    q.delete();
    cq.delete();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    do_reset();
    #1;
    checks++;
    if (got !== ex_t'('0)) begin
      failures++;
      $display("FAIL reset_ex got=%h want=0", got);
    end
    checks++;
    if (bubble_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%h want=0", bubble_cnt);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_pass_through();
    ex_t e;
    logic [31:0] c;
    @(negedge CLK);
    ihit = 1'b1;
    mem_busy = 1'b0;
    flush = 1'b0;
    nx = rand_nx();
    nx.rdat1 = 32'hDEAD_BEEF;
    nx.reg_wr = 1'b1;
    nx.dren = 1'b0;
    push_exp();
    advance(e, c);
    checks++;
    if (got.rdat1 !== 32'hDEAD_BEEF || got.reg_wr !== 1'b1) begin
      failures++;
      $display("FAIL pass_rdat1 got=%h/%b want=deadbeef/1",
               got.rdat1, got.reg_wr);
    end
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL pass_bus got=%h want=%h", got, e);
    end
  endtask

  task automatic load_lw(input logic [4:0] dst);
    ex_t e;
    logic [31:0] c;
    @(negedge CLK);
    ihit = 1'b1;
    mem_busy = 1'b0;
    flush = 1'b0;
    nx = rand_nx();
    nx.dren = 1'b1;
    nx.reg_wr = 1'b1;
    nx.reg_dst = dst;
    nx.rs = 5'd0;
    nx.rt = 5'd0;
    push_exp();
    advance(e, c);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL lw_load got=%h want=%h", got, e);
    end
  endtask

  task automatic test_load_use();
    ex_t e;
    logic [31:0] c;
    logic [31:0] c0;
    load_lw(5'd8);
    c0 = bubble_cnt;
    @(negedge CLK);
    nx = rand_nx();
    nx.rs = 5'd8;
    nx.rt = 5'd1;
    #1;
    checks++;
    if (stall_id !== 1'b1) begin
      failures++;
      $display("FAIL lu_stall got=%b want=1", stall_id);
    end
    push_exp();
    advance(e, c);
    checks++;
    if (got !== ex_t'('0) || got !== e) begin
      failures++;
      $display("FAIL lu_bubble got=%h want=0", got);
    end
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL lu_release got=%b want=0", stall_id);
    end
    checks++;
    if (bubble_cnt !== c) begin
      failures++;
      $display("FAIL lu_cnt got=%h want=%h", bubble_cnt, c);
    end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== c0 + 32'd1) begin
      failures++;
      $display("FAIL lu_cnt_inc got=%h want=%h",
               bubble_cnt, c0 + 32'd1);
    end
`endif
    @(negedge CLK);
    push_exp();
    advance(e, c);
    checks++;
    if (got !== e || got.rs !== 5'd8) begin
      failures++;
      $display("FAIL lu_resume got=%h want=%h", got, e);
    end
  endtask

  task automatic test_freeze();
    ex_t e;
    ex_t held;
    logic [31:0] c;
    logic [31:0] c0;
    load_lw(5'd3);
    held = got;
    c0 = bubble_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      mem_busy = 1'b1;
      flush = 1'b1;
      nx = rand_nx();
      nx.rs = 5'd3;
      push_exp();
      advance(e, c);
      checks++;
      if (got !== held || got !== e) begin
        failures++;
        $display("FAIL freeze_%0d got=%h want=%h", i, got, held);
      end
      checks++;
      if (bubble_cnt !== c0 || bubble_cnt !== c) begin
        failures++;
        $display("FAIL freeze_cnt_%0d got=%h want=%h",
                 i, bubble_cnt, c0);
      end
    end
    @(negedge CLK);
    mem_busy = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_flush_priority();
    ex_t e;
    logic [31:0] c;
    load_lw(5'd8);
    @(negedge CLK);
    nx = rand_nx();
    nx.rs = 5'd8;
    nx.halt = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall got=%b want=0", stall_id);
    end
    push_exp();
    advance(e, c);
    checks++;
    if (got !== ex_t'('0) || got.halt !== 1'b0) begin
      failures++;
      $display("FAIL flush_bubble got=%h want=0", got);
    end
    checks++;
    if (bubble_cnt !== c) begin
      failures++;
      $display("FAIL flush_cnt got=%h want=%h", bubble_cnt, c);
    end
    @(negedge CLK);
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    load_lw(5'd8);
    @(negedge CLK);
    nx.rs = 5'd8;
    #1;
    checks++;
    if (stall_id !== 1'b1 || got.reg_wr !== 1'b1) begin
      failures++;
      $display("FAIL ar_pre got=%b/%b want=1/1",
               stall_id, got.reg_wr);
    end
    #1;
    do_reset();
    #1;
    checks++;
    if (got.reg_wr !== 1'b0 || got !== ex_t'('0)) begin
      failures++;
      $display("FAIL ar_ex got=%h want=0", got);
    end
    checks++;
    if (bubble_cnt !== 32'd0) begin
      failures++;
      $display("FAIL ar_cnt got=%h want=0", bubble_cnt);
    end
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL ar_stall got=%b want=0", stall_id);
    end
    nx.rs = 5'd0;
    nx.rt = 5'd0;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin
      failures++;
      $display("FAIL ar_zero_stall got=%b want=0", stall_id);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_saturation();
    ex_t e;
    logic [31:0] c;
    @(negedge CLK);
`ifdef IDEX_PERF_CNT_EN
    dut.cnt_q = 32'hFFFF_FFFE;
    mcnt = 32'hFFFF_FFFE;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ihit = 1'b1;
      mem_busy = 1'b0;
      flush = 1'b1;
      nx = rand_nx();
      push_exp();
      advance(e, c);
      checks++;
      if (bubble_cnt !== c) begin
        failures++;
        $display("FAIL sat_cnt_%0d got=%h want=%h",
                 i, bubble_cnt, c);
      end
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL sat_ex_%0d got=%h want=%h", i, got, e);
      end
    end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sat_final got=%h want=ffffffff", bubble_cnt);
    end
`else
    checks++;
    if (bubble_cnt !== 32'd0) begin
      failures++;
      $display("FAIL nocnt_final got=%h want=0", bubble_cnt);
    end
`endif
    @(negedge CLK);
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    ex_t e;
    logic [31:0] c;
    logic want;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      ihit = ($urandom_range(0, 3) != 0);
      mem_busy = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      nx = rand_nx();
      #1;
      want = model_lu() & ~flush;
      checks++;
      if (stall_id !== want) begin
        failures++;
        $display("FAIL b2b_stall_%0d got=%b want=%b",
                 i, stall_id, want);
      end
      push_exp();
      advance(e, c);
      checks++;
      if (got !== e || bubble_cnt !== c) begin
        failures++;
        $display("FAIL b2b_ex_%0d got=%h/%h want=%h/%h",
                 i, got, bubble_cnt, e, c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_freeze();
    test_flush_priority();
    test_async_reset();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
